seq_multiplier: RTL

- Iterative unsigned shift-add multiplier for the basic RISC-V datapath; consumes a bitwise-AND partial-product row each cycle and accumulates it.
- Sits beside the ALU in the execute stage and services MUL/MULHU.
- The issue logic drives operands with a start strobe and waits for a one-cycle done pulse.
- Fixed latency, one operation in flight.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/seq_multiplier_if.sv | 24 ++
 rtl/and_gate.sv | 11 +
 rtl/seq_multiplier_pp_row.sv | 19 +
 rtl/seq_multiplier.sv | 98 +++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared execute-stage definitions.
// Multiplier state encoding and sizing helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    IDLE,
    RUN
  } mul_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_w(XLEN);

endpackage

// File: rtl/seq_multiplier_if.sv
// Issue-side handshake bundle for the
// iterative multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = riscv_pkg::XLEN
) ();

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/and_gate.sv
// Two-input AND library cell.
// Leaf of the partial-product row.
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/seq_multiplier_pp_row.sv
// One partial-product row: vec gated
// by a single multiplier bit.
module pp_row #(
  parameter int N = 64
) (
  input  logic [N-1:0] vec,
  input  logic         sel,
  output logic [N-1:0] row
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    and_gate u_and (
      .a (vec[i]),
      .b (sel),
      .y (row[i])
    );
  end

endmodule

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier, one
// row per cycle, WIDTH+1 edge latency.
module seq_multiplier
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_w(WIDTH);

  mul_state_t       state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PW-1:0]    row;
  logic [PW-1:0]    sum;
  logic             last;

  pp_row #(.N(PW)) u_row (
    .vec (mcand_q),
    .sel (mplier_q[0]),
    .row (row)
  );

  assign sum  = acc_q + row;
  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = PW'(bus.a);
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          prod_d  = sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = prod_q;

endmodule
